// File: rtl/bckt_sched.sv
// Round-robin bucket scheduler: grants one flash channel at a time and launches the intersection engine.
// Optional watchdog abort enabled by defining BCKT_SCHED_TIMEOUT_EN.
module bckt_sched #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned BID_W   = 16,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_CH-1:0]         ch_req,
    input  logic [N_CH*BID_W-1:0]   ch_bid,
    output logic [N_CH-1:0]         ch_gnt,
    output logic                    eng_start,
    output logic [BID_W-1:0]        eng_bid,
    input  logic                    eng_done,
    output logic                    eng_abort,
    output logic                    busy,
    output logic [$clog2(N_CH)-1:0] cur_ch,
    output logic [CNT_W-1:0]        bckt_cnt,
    output logic                    timeout_err
);

    localparam int unsigned CH_W = $clog2(N_CH);

    if (N_CH < 2 || TIMEOUT == 0) begin : g_param_err
        $error("bckt_sched: requires N_CH >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  win_ch;
    logic             win_vld;
    logic [CH_W:0]    scan_sum;
    logic [CH_W-1:0]  scan_idx;
    logic             launch;
    logic             done_hit;
    logic             abort_hit;
    logic [BID_W-1:0] bid_arr [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_bid
        assign bid_arr[i] = ch_bid[i*BID_W +: BID_W];
    end

    // First requester at or above rr_ptr wins, wrapping at N_CH
    always_comb begin
        win_vld  = 1'b0;
        win_ch   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            scan_sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (scan_sum >= (CH_W+1)'(N_CH)) begin
                scan_sum = scan_sum - (CH_W+1)'(N_CH);
            end
            scan_idx = scan_sum[CH_W-1:0];
            if (!win_vld && ch_req[scan_idx]) begin
                win_vld = 1'b1;
                win_ch  = scan_idx;
            end
        end
    end

    assign launch   = (state == IDLE) && enable && win_vld;
    assign done_hit = (state == WAIT) && eng_done;

`ifdef BCKT_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt;

    // Abort on the WAIT cycle whose count would reach TIMEOUT; a simultaneous done wins
    assign abort_hit = (state == WAIT) && !eng_done && (wait_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            wait_cnt <= '0;
        end else if (!eng_done) begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (done_hit || abort_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and scheduler bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_gnt      <= '0;
            eng_start   <= 1'b0;
            eng_bid     <= '0;
            eng_abort   <= 1'b0;
            busy        <= 1'b0;
            cur_ch      <= '0;
            bckt_cnt    <= '0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            ch_gnt    <= '0;
            eng_start <= 1'b0;
            eng_abort <= abort_hit;
            busy      <= (state_nxt != IDLE);
            if (launch) begin
                cur_ch    <= win_ch;
                eng_bid   <= bid_arr[win_ch];
                ch_gnt    <= N_CH'(1) << win_ch;
                eng_start <= 1'b1;
            end
            if (state == START) begin
                rr_ptr <= (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + CH_W'(1);
            end
            if (done_hit) begin
                bckt_cnt <= bckt_cnt + CNT_W'(1);
            end
            if (abort_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
